// File: rtl/icache_pkg.sv
// Shared types and width helpers for the
// direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REFILL,
    DONE
  } icache_state_t;

  localparam int XLEN = 32;

  function automatic int off_w(input int wpl);
    return $clog2(wpl);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(
    input int lines,
    input int wpl
  );
    return XLEN - 2 - idx_w(lines) - off_w(wpl);
  endfunction

endpackage

// File: rtl/icache_ram.sv
// Synchronous single-port RAM used for the
// cache tag and data arrays.
module icache_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache
// between the imem port and a refill bus.
module icache_fetch
  import icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] imem_address,
  input  logic        imem_enable,
  output logic [31:0] imem_data,
  output logic        imem_wait,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_address,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int OFF_W = off_w(WORDS_PER_LINE);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(LINES, WORDS_PER_LINE);
  localparam int LSB   = OFF_W + 2;
  localparam int DW    = LINES * WORDS_PER_LINE;

  icache_state_t state_q, state_d;

  logic [31:0]      req_addr_q;
  logic             pending_q;
  logic [LINES-1:0] valid_q;
  logic             valid_rd_q;
  logic [OFF_W-1:0] cnt_q;
  logic [31:0]      data_q;
  logic             flushed_q;

  logic [TAG_W-1:0] tag_rdata;
  logic [31:0]      ram_rdata;

  logic [OFF_W-1:0] in_off, req_off;
  logic [IDX_W-1:0] in_idx, req_idx;
  logic [TAG_W-1:0] req_tag;

  logic lookup, hit, miss, accept;
  logic refill, resp_we, last;

  logic unused_addr_bits;

  assign in_off  = imem_address[LSB-1:2];
  assign in_idx  = imem_address[LSB+IDX_W-1:LSB];
  assign req_off = req_addr_q[LSB-1:2];
  assign req_idx = req_addr_q[LSB+IDX_W-1:LSB];
  assign req_tag = req_addr_q[31:LSB+IDX_W];

  assign unused_addr_bits =
    ^{imem_address[1:0], req_addr_q[1:0]};

  assign lookup = (state_q == IDLE) && pending_q;
  assign hit    = lookup && valid_rd_q
               && (tag_rdata == req_tag);
  assign miss   = lookup && !hit;

  assign refill  = (state_q == REFILL);
  assign resp_we = refill && mem_resp_valid;
  assign last    = resp_we && (cnt_q == '1);

  assign imem_wait = miss
                  || (state_q == REQ)
                  || refill;
  assign accept    = imem_enable && !imem_wait;

  // Hits bypass the data register so back-to-back
  // fetches deliver one word per cycle.
  assign imem_data = hit ? ram_rdata : data_q;

  assign mem_req_valid   = (state_q == REQ);
  assign mem_req_address =
    {req_addr_q[31:LSB], {LSB{1'b0}}};

  icache_ram #(
    .WIDTH(TAG_W),
    .DEPTH(LINES)
  ) u_tag_ram (
    .clk  (clk),
    .en   (accept),
    .we   (last),
    .addr (refill ? req_idx : in_idx),
    .wdata(req_tag),
    .rdata(tag_rdata)
  );

  icache_ram #(
    .WIDTH(32),
    .DEPTH(DW)
  ) u_data_ram (
    .clk  (clk),
    .en   (accept),
    .we   (resp_we),
    .addr (refill ? {req_idx, cnt_q}
                  : {in_idx, in_off}),
    .wdata(mem_resp_data),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (miss) state_d = REQ;
      REQ:    if (mem_req_ready) state_d = REFILL;
      REFILL: if (last) state_d = DONE;
      DONE:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      pending_q  <= 1'b0;
      valid_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_addr_q <= imem_address;
        valid_rd_q <= valid_q[in_idx];
      end
      if (accept) begin
        pending_q <= 1'b1;
      end else if (hit || state_q == DONE) begin
        pending_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      if (hit) begin
        data_q <= ram_rdata;
      end
      if (state_q == REQ) begin
        cnt_q <= '0;
      end else if (resp_we) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == req_off) begin
          data_q <= mem_resp_data;
        end
      end
    end
  end

  // A flush seen mid-refill keeps the fetched
  // line from being published as valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= '0;
      flushed_q <= 1'b0;
    end else begin
      if (state_q == REQ || refill) begin
        flushed_q <= flushed_q | flush;
      end else begin
        flushed_q <= 1'b0;
      end
      if (flush) begin
        valid_q <= '0;
      end else if (last && !flushed_q) begin
        valid_q[req_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache between the core's instruction-fetch port and a variable-latency request/response memory bus.
- On the core side it presents the existing synchronous imem contract: address accepted on `imem_enable`, data one cycle later, and `imem_wait` to stall the pipe.
- A miss triggers a line refill over the bus.
- A flush input invalidates the cache (`fence.i`, program load).

Parameters:
- LINES, 16, number of cache lines (power of two, ≥2)
- WORDS_PER_LINE, 4, 32-bit words per line (power of two, ≥2)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- imem_address  in  32  fetch address from core; bits [1:0] ignored
- imem_enable  in  1  fetch request; address sampled this cycle
- imem_data  out  32  instruction for the last accepted address
- imem_wait  out  1  high while the last accepted fetch is not yet satisfied
- flush  in  1  invalidate all lines
- mem_req_valid  out  1  line refill request
- mem_req_ready  in  1  bus accepts request
- mem_req_address  out  32  line-aligned refill address
- mem_resp_valid  in  1  one refill word valid
- mem_resp_data  in  32  refill word; words arrive in ascending address order

Behaviour:
- Reset (async, reset_n=0):
  - all valid bits cleared; state IDLE; pending flag cleared
  - imem_data=0, imem_wait=0, mem_req_valid=0, mem_req_address=0
- Address split:
  - offset = [log2(WORDS_PER_LINE)+1:2]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage:
  - tag/valid and data arrays are read synchronously with imem_address in the cycle imem_enable is high.
  - The address is also registered as req_addr and the pending flag is set.
- States: IDLE, REQ, REFILL, DONE.
- IDLE, pending set (cycle T+1 after enable at T):
  - Hit (valid & tag match): imem_data = array word, imem_wait=0, pending cleared.
  - Hit while imem_enable is high again: the new fetch is accepted; back-to-back hits sustain one word per cycle.
  - Miss: imem_wait=1 combinationally; next state REQ.
- IDLE, pending clear: imem_wait=0; imem_data holds its last value.
- REQ:
  - mem_req_valid=1; mem_req_address = {req_addr tag,index, zero offset, 2'b00}.
  - Request is held stable until mem_req_ready; then REFILL with word counter=0.
  - imem_wait=1.
- REFILL:
  - On each mem_resp_valid: write mem_resp_data into the line at the counter, then increment the counter.
  - If counter == req_addr offset, also capture the word into the imem_data register.
  - After word WORDS_PER_LINE-1: write tag, set valid, go to DONE.
  - imem_wait=1 throughout; cycles without mem_resp_valid simply wait.
- DONE (one cycle):
  - imem_wait=0; imem_data = captured word; pending cleared; next state IDLE.
  - imem_enable in DONE is accepted as a normal fetch.
- imem_enable while imem_wait=1 is ignored. The core cannot produce this, because its pipe is stalled then.
- imem_data is stable from the cycle imem_wait drops until the cycle after the next accepted imem_enable.
- Flush:
  - All valid bits clear at the next edge.
  - Flush during REQ/REFILL: the refill completes and the fetch is served, but the line is not marked valid.
  - Flush coincident with a hit lookup: the hit is served; the line is invalidated afterwards.
- Mid-operation reset aborts any refill: state IDLE, mem_req_valid drops immediately. The bus owner discards any outstanding response.
- No bus error handling; responses are always complete lines.

Decomposition:
- icache_pkg holds:
  - state enum icache_state_t {IDLE, REQ, REFILL, DONE}
  - localparam helpers for offset/index/tag widths as functions of the parameters
- One sub-module, icache_ram: a parameterised synchronous single-port RAM (read on enable, write on we), instanced for tag+valid and for data.
- Valid bits live in flops in icache_fetch so that reset and flush clear them in one cycle.

Test Plan:
- Cold miss: enable addr 0x10 → mem_req_address=0x10, ready next cycle, responses 0xA0,0xA1,0xA2,0xA3 → imem_wait high 6+ cycles, DONE cycle imem_data=0xA0, imem_wait=0.
- Hit stream after the cold miss: enables at 0x10,0x14,0x18,0x1C on consecutive cycles → data 0xA0..0xA3 on consecutive cycles, imem_wait never asserted, no bus request.
- Conflict: fetch 0x110 (same index 1, tag differs) → refill at 0x110; subsequent fetch of 0x10 misses again and requests 0x10.
- Bus backpressure: mem_req_ready low 5 cycles, responses gapped by 2 idle cycles, critical word is offset 2 (addr 0x28) → mem_req_address stable while unready; imem_data=word 2 in DONE.
- Flush during refill of 0x40, then refetch 0x40 → first fetch served; second fetch misses and issues a new request.
- Async reset asserted mid-REFILL → mem_req_valid and imem_wait drop without waiting for a clock edge; after release, fetch 0x10 misses (valid cleared).
